// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array column drain.
package sa_pkg;

  localparam int SHIFT_W = 6;

  typedef enum logic [1:0] {DR_IDLE, DR_ISSUE, DR_TAIL, DR_DONE} drain_state_t;

endpackage

// File: rtl/sa_drain_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sa_drain_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // A write into a full FIFO is only taken when the same cycle frees a slot.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    push     = wr_en && ((count_q != CW'(DEPTH)) || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/sa_col_drain.sv
// Column drain: sequences the PE buffer shift, captures each word at the column bottom,
// rescales and narrows it into an output FIFO. Optional SA_DRAIN_SAT_EN selects saturation.
module sa_col_drain
  import sa_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 48,
  parameter int OUT_WIDTH  = 32,
  parameter int DRAIN_LAT  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     drain_req_in,
  input  logic [SHIFT_W-1:0]       shift_in,
  input  logic [DATA_WIDTH-1:0]    bottom_in,
  output logic                     sys_buf_en_out,
  output logic                     psu_clr_out,
  output logic                     drain_busy_out,
  output logic                     drain_done_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic [$clog2(ROWS)-1:0]  out_row
`ifdef SA_DRAIN_SAT_EN
  ,
  output logic                     sat_flag_out
`endif
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int FW      = OUT_WIDTH + ROW_W;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (ROWS > DRAIN_LAT) ? ROWS : DRAIN_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  drain_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                pending_q, pending_d;
  logic [DRAIN_LAT-1:0] cap_q, cap_d;
  logic [ROW_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic                cap_vld, space_ok, accept;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [FW-1:0]       fifo_rd;
  logic [ROW_W-1:0]    cap_row;
  logic [OUT_WIDTH-1:0] narrowed;

  // Reserving ROWS free entries at accept guarantees no capture push can be refused.
  assign space_ok = (fifo_count <= CW'(FIFO_DEPTH - ROWS));
  assign accept   = (state_q == DR_IDLE) && (drain_req_in || pending_q) && space_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    case (state_q)
      DR_IDLE: begin
        if (accept) begin
          state_d   = DR_ISSUE;
          cnt_d     = '0;
          shift_d   = shift_in;
          pending_d = 1'b0;
        end else if (drain_req_in) begin
          pending_d = 1'b1;
        end
      end
      DR_ISSUE: begin
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          state_d = DR_TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DR_TAIL: begin
        if (cnt_q == CNT_W'(DRAIN_LAT - 1)) state_d = DR_DONE;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = DR_IDLE;
    endcase
  end

  // Capture strobe is the issue strobe seen DRAIN_LAT cycles later.
  always_comb begin
    cap_d     = (cap_q << 1) | DRAIN_LAT'(sys_buf_en_out);
    cap_cnt_d = cap_vld ? cap_cnt_q + 1'b1 : cap_cnt_q;
    if (state_q == DR_DONE) cap_cnt_d = '0;
  end

  assign cap_vld = cap_q[DRAIN_LAT-1];
  assign cap_row = ROW_W'(ROWS - 1) - cap_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DR_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      cap_q     <= '0;
      cap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      cap_q     <= cap_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

`ifdef SA_DRAIN_SAT_EN
  logic signed [DATA_WIDTH-1:0] shifted;
  logic                         clamp;
  logic                         sat_q, sat_d;

  // Out of range when the bits above the output sign are not all copies of it.
  always_comb begin
    shifted = $signed(bottom_in) >>> shift_q;
    clamp   = (shifted[DATA_WIDTH-1:OUT_WIDTH-1] !=
               {(DATA_WIDTH-OUT_WIDTH+1){shifted[DATA_WIDTH-1]}});
    if (!clamp)                    narrowed = shifted[OUT_WIDTH-1:0];
    else if (shifted[DATA_WIDTH-1]) narrowed = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                           narrowed = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    sat_d = sat_q | (cap_vld & clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag_out = sat_q;
`else
  assign narrowed = OUT_WIDTH'($signed(bottom_in) >>> shift_q);
`endif

  sa_drain_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_vld),
    .wr_data ({cap_row, narrowed}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign sys_buf_en_out = (state_q == DR_ISSUE);
  assign drain_done_out = (state_q == DR_DONE);
  assign psu_clr_out    = (state_q == DR_DONE);
  assign drain_busy_out = (state_q != DR_IDLE) || pending_q;
  assign out_valid      = !fifo_empty;
  // Gate the stream fields so idle outputs read as zero rather than stale RAM.
  assign out_data       = out_valid ? fifo_rd[OUT_WIDTH-1:0] : '0;
  assign out_row        = out_valid ? fifo_rd[FW-1:OUT_WIDTH] : '0;

endmodule

// File: tb/tb_sa_col_drain.sv
// Self-checking bench for sa_col_drain: column model drives bottom_in, scoreboard checks the stream.
`timescale 1ns/1ps
module tb_sa_col_drain;

  localparam int ROWS = 4;
  localparam int DW   = 48;
  localparam int OW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          drain_req_in;
  logic [5:0]    shift_in;
  logic [DW-1:0] bottom_in;
  logic          sys_buf_en_out, psu_clr_out, drain_busy_out, drain_done_out, out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_row;
`ifdef SA_DRAIN_SAT_EN
  logic          sat_flag_out;
`endif

  always #5 clk = ~clk;

  sa_col_drain dut (
    .clk            (clk),
    .rst            (rst),
    .drain_req_in   (drain_req_in),
    .shift_in       (shift_in),
    .bottom_in      (bottom_in),
    .sys_buf_en_out (sys_buf_en_out),
    .psu_clr_out    (psu_clr_out),
    .drain_busy_out (drain_busy_out),
    .drain_done_out (drain_done_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row)
`ifdef SA_DRAIN_SAT_EN
    ,
    .sat_flag_out   (sat_flag_out)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } word_t;

  word_t       exp_q[$];
  logic [47:0] col_q[$];
  logic [31:0] got_d[$];
  logic [1:0]  got_r[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          done_seen = 0;
  logic        exp_sat   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint scaled(input logic [47:0] w, input int sh);
    longint v;
    v = longint'($signed(w));
    return v >>> sh;
  endfunction

  function automatic logic [31:0] narrow(input longint v);
`ifdef SA_DRAIN_SAT_EN
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(v);
  endfunction

  // The column delivers its words bottom PE first, tagged ROWS-1 down to 0.
  task automatic enqueue(input logic [47:0] w0, w1, w2, w3, input int sh);
    logic [47:0] w[4];
    longint      v;
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      v = scaled(w[i], sh);
      col_q.push_back(w[i]);
      exp_q.push_back('{narrow(v), 2'(3 - i)});
      if (v > 64'sd2147483647 || v < -64'sd2147483648) exp_sat = 1'b1;
    end
  endtask

  task automatic drain(input logic [47:0] w0, w1, w2, w3, input int sh);
    enqueue(w0, w1, w2, w3, sh);
    @(posedge clk); #1;
    shift_in     = 6'(sh);
    drain_req_in = 1'b1;
    $display("[TB] drain request shift=%0d", sh);
    @(posedge clk); #1;
    drain_req_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!drain_busy_out && !out_valid && exp_q.size() == 0 && col_q.size() == 0) break;
    end
    chk({name, "_idle_timeout"}, 64'(k >= 300), 64'd0);
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!drain_busy_out) break;
    end
    chk({name, "_busy_timeout"}, 64'(k >= 100), 64'd0);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_r.delete();
  endtask

  // Column model: a word appears at the bottom DRAIN_LAT=2 cycles after each buffer shift.
  initial begin
    logic [1:0] hist;
    hist = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        hist      = 2'b00;
        bottom_in = '0;
      end else begin
        if (hist[1]) begin
          if (col_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_issue: buffer shift beyond %0d rows, expected none", ROWS);
            bottom_in = '0;
          end else begin
            bottom_in = col_q.pop_front();
          end
        end else begin
          bottom_in = {16'($urandom), 32'($urandom)};
        end
        hist = {hist[0], sys_buf_en_out};
      end
    end
  end

  // Scoreboard: every valid cycle must show the head of the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drain_done_out || psu_clr_out) begin
          chk("done_with_clr", {62'd0, drain_done_out, psu_clr_out}, 64'd3);
          if (drain_done_out) done_seen++;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got data %08h row %0d, expected none", out_data, out_row);
          end else begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_row", out_row, exp_q[0].r);
            if (out_ready) begin
              $display("[TB] pop row %0d data %08h", out_row, out_data);
              got_d.push_back(out_data);
              got_r.push_back(out_row);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    logic [47:0] rw[8];

    rst          = 1'b1;
    drain_req_in = 1'b0;
    out_ready    = 1'b1;
    shift_in     = '0;
    bottom_in    = '0;

    // Reset state: every output low, during reset and after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {sys_buf_en_out, psu_clr_out, drain_busy_out, drain_done_out,
                        out_valid, out_data, out_row}, 64'd0);
`ifdef SA_DRAIN_SAT_EN
    chk("rst_sat", sat_flag_out, 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outputs", {sys_buf_en_out, psu_clr_out, drain_busy_out, drain_done_out,
                           out_valid, out_data, out_row}, 64'd0);
    end

    // Basic drain with cycle-exact issue and done timing.
    clear_got();
    d0 = done_seen;
    enqueue(48'd10, 48'd20, 48'd30, 48'd40, 0);
    @(posedge clk); #1;
    shift_in     = 6'd0;
    drain_req_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      drain_req_in = 1'b0;
      @(negedge clk);
      chk($sformatf("t2_sbe_c%0d", c), sys_buf_en_out, 64'(c <= 4));
      chk($sformatf("t2_done_c%0d", c), drain_done_out, 64'(c == 7));
    end
    wait_idle("t2");
    chk("t2_w0", got_d[0], 64'd10);
    chk("t2_w1", got_d[1], 64'd20);
    chk("t2_w2", got_d[2], 64'd30);
    chk("t2_w3", got_d[3], 64'd40);
    chk("t2_rows", {got_r[0], got_r[1], got_r[2], got_r[3]}, 64'b11_10_01_00);
    chk("t2_done_count", done_seen - d0, 64'd1);

    // Arithmetic shift with sign extension.
    clear_got();
    drain(48'hFFFF_FFFF_FF00, 48'h0000_0000_1230, 48'hFFFF_FFFF_FFFF, 48'h0000_7FFF_FFF0, 4);
    wait_idle("t3");
    chk("t3_neg256", got_d[0], 64'hFFFF_FFF0);
    chk("t3_pos", got_d[1], 64'h0000_0123);
    chk("t3_minus1", got_d[2], 64'hFFFF_FFFF);
    chk("t3_big", got_d[3], 64'h07FF_FFFF);

    // Reset in the middle of ISSUE aborts cleanly.
    clear_got();
    d0 = done_seen;
    drain(48'd1, 48'd2, 48'd3, 48'd4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    col_q.delete();
    exp_q.delete();
    exp_sat = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_sbe_after_rst", sys_buf_en_out, 64'd0);
    chk("t1_valid_after_rst", out_valid, 64'd0);
    chk("t1_busy_after_rst", drain_busy_out, 64'd0);
    repeat (12) @(negedge clk);
    chk("t1_no_done", done_seen - d0, 64'd0);
    drain(48'd5, 48'd6, 48'd7, 48'd8, 0);
    wait_idle("t1");
    chk("t1_redrain_words", got_d.size(), 64'd4);
    chk("t1_redrain_w0", got_d[0], 64'd5);
    chk("t1_redrain_done", done_seen - d0, 64'd1);

    // Back-pressure: third drain waits until four entries free up.
    clear_got();
    d0 = done_seen;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drain(48'd101, 48'd102, 48'd103, 48'd104, 1);
    wait_not_busy("t4a");
    drain(48'd201, 48'd202, 48'd203, 48'd204, 1);
    wait_not_busy("t4b");
    drain(48'd301, 48'd302, 48'd303, 48'd304, 1);
    repeat (10) begin
      @(negedge clk);
      chk("t4_pending_busy", drain_busy_out, 64'd1);
      chk("t4_pending_no_issue", sys_buf_en_out, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk);
        if (sys_buf_en_out) break;
      end
      chk("t4_pending_starts", 64'(k < 10), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("t4");
    chk("t4_words", got_d.size(), 64'd12);
    chk("t4_first_a", got_d[0], 64'd50);
    chk("t4_first_c", got_d[8], 64'd150);
    chk("t4_done_count", done_seen - d0, 64'd3);

    // Ready toggling every cycle across two drains.
    clear_got();
    d0 = done_seen;
    for (int i = 0; i < 8; i++) rw[i] = 48'($urandom & 32'h3FFF_FFFF);
    fork
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join_none
    drain(rw[0], rw[1], rw[2], rw[3], 2);
    wait_not_busy("t6a");
    drain(rw[4], rw[5], rw[6], rw[7], 3);
    wait_idle("t6");
    repeat (45) @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("t6_words", got_d.size(), 64'd8);
    chk("t6_done_count", done_seen - d0, 64'd2);

    // A request while busy is dropped.
    clear_got();
    d0 = done_seen;
    drain(48'd11, 48'd12, 48'd13, 48'd14, 0);
    @(posedge clk); #1;
    drain_req_in = 1'b1;
    @(posedge clk); #1;
    drain_req_in = 1'b0;
    wait_idle("tdrop");
    repeat (10) begin
      @(negedge clk);
      chk("tdrop_quiet", {sys_buf_en_out, out_valid}, 64'd0);
    end
    chk("tdrop_words", got_d.size(), 64'd4);
    chk("tdrop_done_count", done_seen - d0, 64'd1);

    // Narrowing of out-of-range values.
    clear_got();
`ifdef SA_DRAIN_SAT_EN
    chk("t5_sat_before", sat_flag_out, exp_sat);
`endif
    drain(48'h0001_0000_0000, 48'hFFFE_0000_0000, 48'd5, 48'hFFFF_FFFF_FFFA, 0);
    wait_idle("t5");
`ifdef SA_DRAIN_SAT_EN
    chk("t5_pos_clamp", got_d[0], 64'h7FFF_FFFF);
    chk("t5_neg_clamp", got_d[1], 64'h8000_0000);
    chk("t5_sat_flag", sat_flag_out, 64'd1);
`else
    chk("t5_pos_trunc", got_d[0], 64'h0000_0000);
    chk("t5_neg_trunc", got_d[1], 64'h0000_0000);
`endif
    chk("t5_small", got_d[2], 64'd5);
    chk("t5_minus6", got_d[3], 64'hFFFF_FFFA);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_sat = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
`ifdef SA_DRAIN_SAT_EN
    chk("t5_sat_cleared", sat_flag_out, 64'd0);
`endif
    chk("t5_valid_cleared", out_valid, 64'd0);

    chk("leftover_expected", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
